// File: rtl/alu_pkg.sv
// alu_pkg: shared constants for the EX-stage integer unit.
//   - base op codes (funct3 with MEXT=0)
//   - M-extension op codes (funct3 with MEXT=1)
//   - top-level sequencing state
package alu_pkg;

   localparam logic [2:0] OP_ADD  = 3'd0;
   localparam logic [2:0] OP_SLL  = 3'd1;
   localparam logic [2:0] OP_SLT  = 3'd2;
   localparam logic [2:0] OP_SLTU = 3'd3;
   localparam logic [2:0] OP_XOR  = 3'd4;
   localparam logic [2:0] OP_SRL  = 3'd5;   // SRA when ROTATE=1
   localparam logic [2:0] OP_OR   = 3'd6;
   localparam logic [2:0] OP_AND  = 3'd7;

   localparam logic [2:0] M_MUL    = 3'd0;
   localparam logic [2:0] M_MULH   = 3'd1;
   localparam logic [2:0] M_MULHSU = 3'd2;
   localparam logic [2:0] M_MULHU  = 3'd3;
   localparam logic [2:0] M_DIV    = 3'd4;
   localparam logic [2:0] M_DIVU   = 3'd5;
   localparam logic [2:0] M_REM    = 3'd6;
   localparam logic [2:0] M_REMU   = 3'd7;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DIV  = 2'd2
   } state_e;

endpackage

// File: rtl/mdu_iter.sv
// mdu_iter: iterative radix-2 multiply / restoring divide.
//   clk, rst_n   clock, async active-low reset
//   start_i      latch operands and begin (one-cycle pulse)
//   op_i         M op code (bit 2: divide, bit 1/0: variant)
//   a_i, b_i     raw operands rs1/rs2, sampled on start_i
//   done_o       high in the cycle whose edge performs the last iteration
//   result_o     final, sign-corrected result, valid while done_o is high
module mdu_iter
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start_i,
   input  logic [2:0]       op_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic             done_o,
   output logic [WIDTH-1:0] result_o
);

   localparam int SHW = $clog2(WIDTH);

   logic               run_q, div_q, neg_q, negr_q;
   logic [1:0]         op_q;
   logic [SHW-1:0]     cnt_q;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0]   mcand_q;

   // Operand signedness per op; magnitudes are what the datapath iterates on.
   logic             s1, s2, na, nb;
   logic [WIDTH-1:0] mag_a, mag_b;

   assign s1    = op_i[2] ? ~op_i[0] : (op_i[1:0] != M_MULHU[1:0]);
   assign s2    = op_i[2] ? ~op_i[0] : ~op_i[1];
   assign na    = s1 & a_i[WIDTH-1];
   assign nb    = s2 & b_i[WIDTH-1];
   assign mag_a = na ? -a_i : a_i;
   assign mag_b = nb ? -b_i : b_i;

   // Multiply step: add multiplicand into upper half when the multiplier LSB
   // is set, then shift the whole {carry, hi, lo} right by one.
   logic [WIDTH:0] sum;
   assign sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);

   // Divide step: acc = {remainder, remaining dividend / quotient bits}.
   // Partial remainder < divisor, so the trial difference fits in WIDTH+1 bits.
   logic [WIDTH:0] sh, diff;
   assign sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
   assign diff = sh - {1'b0, mcand_q};

   always_comb begin
      acc_d = acc_q;
      if (div_q) begin
         if (!diff[WIDTH]) acc_d = {diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
         else              acc_d = {sh[WIDTH-1:0],   acc_q[WIDTH-2:0], 1'b0};
      end else begin
         acc_d = {sum, acc_q[WIDTH-1:1]};
      end
   end

   assign done_o = run_q && (cnt_q == SHW'(WIDTH-1));

   // Sign fix-up is applied to the final accumulator value directly so the
   // result is ready on the same edge as the last iteration.
   logic [2*WIDTH-1:0] full;
   logic [WIDTH-1:0]   quot, rem;
   assign full = neg_q ? -acc_d : acc_d;
   assign quot = acc_d[WIDTH-1:0];
   assign rem  = acc_d[2*WIDTH-1:WIDTH];

   always_comb begin
      result_o = '0;
      if (div_q) result_o = op_q[1] ? (negr_q ? -rem : rem) : (neg_q ? -quot : quot);
      else       result_o = (op_q == 2'd0) ? full[WIDTH-1:0] : full[2*WIDTH-1:WIDTH];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         run_q   <= 1'b0;
         div_q   <= 1'b0;
         neg_q   <= 1'b0;
         negr_q  <= 1'b0;
         op_q    <= '0;
         cnt_q   <= '0;
         acc_q   <= '0;
         mcand_q <= '0;
      end else if (start_i) begin
         run_q   <= 1'b1;
         div_q   <= op_i[2];
         neg_q   <= na ^ nb;
         negr_q  <= na;
         op_q    <= op_i[1:0];
         cnt_q   <= '0;
         acc_q   <= {{WIDTH{1'b0}}, (op_i[2] ? mag_a : mag_b)};
         mcand_q <= op_i[2] ? mag_b : mag_a;
      end else if (run_q) begin
         acc_q <= acc_d;
         cnt_q <= cnt_q + 1'b1;
         if (done_o) run_q <= 1'b0;
      end
   end

endmodule

// File: rtl/alu_mdu_seq.sv
// alu_mdu_seq: EX-stage integer unit, RV32I base ops in one cycle plus
// iterative RV32M multiply/divide.
//   CLK, RESETN            clock, async active-low reset
//   IN_VALID / IN_READY    request handshake (ready only in IDLE)
//   DATA1, DATA2           operands; SELECT funct3; ROTATE SRL/SRA; MEXT M set
//   OUT_VALID              one-cycle pulse, RESULT and flags are new
//   RESULT                 registered result, holds until next OUT_VALID
//   zero_signal, sign_bit_signal   flags of RESULT
//   sltu_bit_signal        unsigned DATA1<DATA2 latched at accept
//   BUSY                   multi-cycle op in flight
module alu_mdu_seq
   import alu_pkg::*;
#(
   parameter  int WIDTH = 32,
   localparam int SHW   = $clog2(WIDTH)
) (
   input  logic             CLK,
   input  logic             RESETN,
   input  logic             IN_VALID,
   output logic             IN_READY,
   input  logic [WIDTH-1:0] DATA1,
   input  logic [WIDTH-1:0] DATA2,
   input  logic [2:0]       SELECT,
   input  logic             ROTATE,
   input  logic             MEXT,
   output logic             OUT_VALID,
   output logic [WIDTH-1:0] RESULT,
   output logic             zero_signal,
   output logic             sign_bit_signal,
   output logic             sltu_bit_signal,
   output logic             BUSY
);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             valid_q, valid_d;
   logic             sltu_q, sltu_d;

   logic             accept, start, special, d2_zero, ovf, sltu;
   logic [SHW-1:0]   shamt;
   logic [WIDTH-1:0] base_res, spec_res, sra_w, mdu_res;
   logic             mdu_done;

   assign accept = IN_VALID && (state_q == ST_IDLE);
   assign shamt  = DATA2[SHW-1:0];
   assign sltu   = DATA1 < DATA2;
   assign sra_w  = $signed(DATA1) >>> shamt;

   always_comb begin
      base_res = '0;
      case (SELECT)
         OP_ADD:  base_res = DATA1 + DATA2;
         OP_SLL:  base_res = DATA1 << shamt;
         OP_SLT:  base_res = {{(WIDTH-1){1'b0}}, ($signed(DATA1) < $signed(DATA2))};
         OP_SLTU: base_res = {{(WIDTH-1){1'b0}}, sltu};
         OP_XOR:  base_res = DATA1 ^ DATA2;
         OP_SRL:  base_res = ROTATE ? sra_w : (DATA1 >> shamt);
         OP_OR:   base_res = DATA1 | DATA2;
         default: base_res = DATA1 & DATA2;
      endcase
   end

   // Divide-by-zero and signed overflow finish in one cycle without iterating.
   // SELECT[0]=0 within the divide group marks the signed ops (DIV, REM).
   assign d2_zero  = (DATA2 == '0);
   assign ovf      = ~SELECT[0] && (DATA1 == {1'b1, {(WIDTH-1){1'b0}}}) && (&DATA2);
   assign special  = SELECT[2] && (d2_zero || ovf);
   assign spec_res = d2_zero ? (SELECT[1] ? DATA1 : '1) : (SELECT[1] ? '0 : DATA1);
   assign start    = accept && MEXT && !special;

   mdu_iter #(.WIDTH(WIDTH)) u_mdu (
      .clk      (CLK),
      .rst_n    (RESETN),
      .start_i  (start),
      .op_i     (SELECT),
      .a_i      (DATA1),
      .b_i      (DATA2),
      .done_o   (mdu_done),
      .result_o (mdu_res)
   );

   always_comb begin
      state_d  = state_q;
      result_d = result_q;
      valid_d  = 1'b0;
      sltu_d   = sltu_q;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               sltu_d = sltu;
               if (start) begin
                  state_d = SELECT[2] ? ST_DIV : ST_MUL;
               end else begin
                  result_d = MEXT ? spec_res : base_res;
                  valid_d  = 1'b1;
               end
            end
         end
         default: begin
            if (mdu_done) begin
               result_d = mdu_res;
               valid_d  = 1'b1;
               state_d  = ST_IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) begin
         state_q  <= ST_IDLE;
         result_q <= '0;
         valid_q  <= 1'b0;
         sltu_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         result_q <= result_d;
         valid_q  <= valid_d;
         sltu_q   <= sltu_d;
      end
   end

   assign IN_READY        = (state_q == ST_IDLE);
   assign BUSY            = (state_q != ST_IDLE);
   assign OUT_VALID       = valid_q;
   assign RESULT          = result_q;
   assign zero_signal     = (result_q == '0);
   assign sign_bit_signal = result_q[WIDTH-1];
   assign sltu_bit_signal = sltu_q;

endmodule
